// File: rtl/ga_pkg.sv
// Shared defaults and types for the gate-array sync/interrupt unit.
package ga_pkg;

    localparam int unsigned INT_LINES   = 52;
    localparam int unsigned VS_INT_DLY  = 2;
    localparam int unsigned HS_DELAY    = 2;
    localparam int unsigned HS_WIDTH    = 4;
    localparam int unsigned VS_LINES    = 26;
    localparam int unsigned MODE_W      = 2;
    localparam int unsigned R52_W       = 6;
    localparam int unsigned REALIGN_MIN = 32;

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StActive
    } hs_state_e;

endpackage

// File: rtl/ga_hsync_shaper.sv
// Monitor hsync shaper: delays the CRTC hsync by HsDelay characters and
// clips it to at most HsWidth characters.
module ga_hsync_shaper
    import ga_pkg::*;
#(
    parameter int unsigned HsDelay = HS_DELAY,
    parameter int unsigned HsWidth = HS_WIDTH
) (
    input  logic i_ck16,
    input  logic i_reset,
    input  logic i_char_en,
    input  logic i_hs_rise,
    input  logic i_hs_fall,
    output logic o_hsync,
    output logic o_start
);

    localparam int unsigned CntMax = (HsDelay > HsWidth) ? HsDelay : HsWidth;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    hs_state_e       r_state, w_state_d;
    logic [CntW-1:0] r_cnt, w_cnt_d;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        o_start   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_hs_rise) begin
                    w_state_d = StDelay;
                    w_cnt_d   = '0;
                end
            end
            // A CRTC hsync that ends before the delay expires never reaches the monitor.
            StDelay: begin
                if (i_hs_fall) begin
                    w_state_d = StIdle;
                end else if (i_char_en) begin
                    if (r_cnt == CntW'(HsDelay - 1)) begin
                        w_state_d = StActive;
                        w_cnt_d   = '0;
                        o_start   = 1'b1;
                    end else begin
                        w_cnt_d = r_cnt + CntW'(1);
                    end
                end
            end
            StActive: begin
                if (i_hs_fall) begin
                    w_state_d = StIdle;
                end else if (i_char_en) begin
                    if (r_cnt == CntW'(HsWidth - 1)) begin
                        w_state_d = StIdle;
                    end else begin
                        w_cnt_d = r_cnt + CntW'(1);
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_ck16) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    assign o_hsync = (r_state == StActive);

endmodule

// File: rtl/ga_sync_int.sv
// Gate-array sync/interrupt unit: line-counted interrupt with vsync realign,
// Z80 acknowledge, monitor hsync/vsync reshaping and per-line mode latch.
module ga_sync_int
    import ga_pkg::*;
#(
    parameter int unsigned IntLines = INT_LINES,
    parameter int unsigned VsIntDly = VS_INT_DLY,
    parameter int unsigned HsDelay  = HS_DELAY,
    parameter int unsigned HsWidth  = HS_WIDTH,
    parameter int unsigned VsLines  = VS_LINES
) (
    input  logic              ck16,
    input  logic              reset,
    input  logic              char_en,
    input  logic              hsync,
    input  logic              vsync,
    input  logic              iorq_n,
    input  logic              m1_n,
    input  logic              irq_clr,
    input  logic [MODE_W-1:0] mode_wr,
    output logic              int_n,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              sync_n,
    output logic [MODE_W-1:0] mode,
    output logic [R52_W-1:0]  r52
);

    localparam int unsigned VcntW = $clog2(VsLines + 1);
    localparam int unsigned VdlyW = $clog2(VsIntDly + 1);

    logic              r_hs, r_hs_d, r_vs, r_vs_d, r_iack;
    logic              w_hs_rise, w_hs_fall, w_vs_rise, w_vs_fall;
    logic              w_iack, w_ack, w_realign, w_hs_start, w_hsync;
    logic [R52_W-1:0]  r_r52, w_r52_d, w_r52_inc;
    logic              r_int_n, w_int_n_d;
    logic [VdlyW-1:0]  r_vdly, w_vdly_d;
    logic [VcntW-1:0]  r_vcnt, w_vcnt_d;
    logic              r_vsync, w_vsync_d;
    logic [MODE_W-1:0] r_mode;

    assign w_hs_rise = r_hs & ~r_hs_d;
    assign w_hs_fall = ~r_hs & r_hs_d;
    assign w_vs_rise = r_vs & ~r_vs_d;
    assign w_vs_fall = ~r_vs & r_vs_d;
    assign w_iack    = ~iorq_n & ~m1_n;
    assign w_ack     = w_iack & ~r_iack;
    assign w_realign = w_hs_fall & (r_vdly == VdlyW'(1));

    ga_hsync_shaper #(
        .HsDelay (HsDelay),
        .HsWidth (HsWidth)
    ) u_hsync_shaper (
        .i_ck16    (ck16),
        .i_reset   (reset),
        .i_char_en (char_en),
        .i_hs_rise (w_hs_rise),
        .i_hs_fall (w_hs_fall),
        .o_hsync   (w_hsync),
        .o_start   (w_hs_start)
    );

    // Acknowledge acts first; the hs_fall update then works on the post-ack count.
    always_comb begin
        w_r52_d   = r_r52;
        w_int_n_d = r_int_n;
        w_r52_inc = '0;
        if (irq_clr) begin
            w_r52_d   = '0;
            w_int_n_d = 1'b1;
        end else begin
            if (w_ack) begin
                w_int_n_d          = 1'b1;
                w_r52_d[R52_W-1]   = 1'b0;
            end
            if (w_hs_fall) begin
                w_r52_inc = w_r52_d + R52_W'(1);
                if (w_realign) begin
                    if (w_r52_d >= R52_W'(REALIGN_MIN)) begin
                        w_int_n_d = 1'b0;
                    end
                    w_r52_d = '0;
                end else if (w_r52_inc == R52_W'(IntLines)) begin
                    w_r52_d   = '0;
                    w_int_n_d = 1'b0;
                end else begin
                    w_r52_d = w_r52_inc;
                end
            end
        end
    end

    always_comb begin
        w_vdly_d = r_vdly;
        if (w_vs_rise) begin
            w_vdly_d = VdlyW'(VsIntDly);
        end else if (w_hs_fall && (r_vdly != '0)) begin
            w_vdly_d = r_vdly - VdlyW'(1);
        end
    end

    always_comb begin
        w_vsync_d = r_vsync;
        w_vcnt_d  = r_vcnt;
        if (w_vs_rise) begin
            w_vsync_d = 1'b1;
            w_vcnt_d  = VcntW'(VsLines);
        end else if (r_vsync) begin
            if (w_vs_fall) begin
                w_vsync_d = 1'b0;
                w_vcnt_d  = '0;
            end else if (w_hs_fall) begin
                w_vcnt_d = r_vcnt - VcntW'(1);
                if (r_vcnt <= VcntW'(1)) begin
                    w_vsync_d = 1'b0;
                    w_vcnt_d  = '0;
                end
            end
        end
    end

    always_ff @(posedge ck16) begin
        if (reset) begin
            r_hs    <= 1'b0;
            r_hs_d  <= 1'b0;
            r_vs    <= 1'b0;
            r_vs_d  <= 1'b0;
            r_iack  <= 1'b0;
            r_r52   <= '0;
            r_int_n <= 1'b1;
            r_vdly  <= '0;
            r_vcnt  <= '0;
            r_vsync <= 1'b0;
            r_mode  <= '0;
        end else begin
            r_hs    <= hsync;
            r_hs_d  <= r_hs;
            r_vs    <= vsync;
            r_vs_d  <= r_vs;
            r_iack  <= w_iack;
            r_r52   <= w_r52_d;
            r_int_n <= w_int_n_d;
            r_vdly  <= w_vdly_d;
            r_vcnt  <= w_vcnt_d;
            r_vsync <= w_vsync_d;
            if (w_hs_start) begin
                r_mode <= mode_wr;
            end
        end
    end

    assign int_n   = r_int_n;
    assign hsync_o = w_hsync;
    assign vsync_o = r_vsync;
    assign sync_n  = ~(w_hsync | r_vsync);
    assign mode    = r_mode;
    assign r52     = r_r52;

endmodule

// File: tb/tb_ga_sync_int.sv
// Directed bench for ga_sync_int: line interrupt, acknowledge, vsync realign,
// monitor sync shaping, mode latch and reset abort.
module tb_ga_sync_int;

    logic       ck16 = 1'b0;
    logic       reset, char_en, hsync, vsync, iorq_n, m1_n, irq_clr;
    logic [1:0] mode_wr;
    logic       int_n, hsync_o, vsync_o, sync_n;
    logic [1:0] mode;
    logic [5:0] r52;

    int checks = 0;
    int errors = 0;

    // Per-line output log, indexed by cycle within the line (4 ck16 per character).
    logic       log_hs   [0:255];
    logic       log_vs   [0:255];
    logic       log_int  [0:255];
    logic       log_sn   [0:255];
    logic [1:0] log_mode [0:255];
    logic [5:0] log_r52  [0:255];

    localparam int LongC  = 64;
    localparam int LongHs = 14;
    localparam int ShortC = 16;
    localparam int ShortHs = 6;
    localparam int LongHf = LongHs * 4 + 1;
    localparam int ShortHf = ShortHs * 4 + 1;

    always #5 ck16 = ~ck16;

    ga_sync_int u_dut (
        .ck16    (ck16),
        .reset   (reset),
        .char_en (char_en),
        .hsync   (hsync),
        .vsync   (vsync),
        .iorq_n  (iorq_n),
        .m1_n    (m1_n),
        .irq_clr (irq_clr),
        .mode_wr (mode_wr),
        .int_n   (int_n),
        .hsync_o (hsync_o),
        .vsync_o (vsync_o),
        .sync_n  (sync_n),
        .mode    (mode),
        .r52     (r52)
    );

    task automatic tick();
        @(posedge ck16);
        #1;
    endtask

    task automatic run_line(input int chars, input int hs_chars, input logic vs,
                            input int clr_idx, input int rst_idx);
        for (int i = 0; i < chars * 4; i++) begin
            char_en = (i % 4 == 0);
            hsync   = (i < hs_chars * 4);
            vsync   = vs;
            irq_clr = (i == clr_idx);
            reset   = (i == rst_idx);
            tick();
            log_hs[i]   = hsync_o;
            log_vs[i]   = vsync_o;
            log_int[i]  = int_n;
            log_sn[i]   = sync_n;
            log_mode[i] = mode;
            log_r52[i]  = r52;
        end
        char_en = 1'b0;
        irq_clr = 1'b0;
        reset   = 1'b0;
    endtask

    task automatic pulse_clr();
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; char_en = 1'b0; hsync = 1'b0; vsync = 1'b0;
        iorq_n = 1'b1; m1_n = 1'b1; irq_clr = 1'b0; mode_wr = 2'd0;
        tick();
        tick();
        checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL rst_int_n: got %b want 1", int_n); end
        checks++; if (hsync_o !== 1'b0) begin errors++; $display("FAIL rst_hsync_o: got %b want 0", hsync_o); end
        checks++; if (vsync_o !== 1'b0) begin errors++; $display("FAIL rst_vsync_o: got %b want 0", vsync_o); end
        checks++; if (sync_n !== 1'b1) begin errors++; $display("FAIL rst_sync_n: got %b want 1", sync_n); end
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL rst_mode: got %0d want 0", mode); end
        checks++; if (r52 !== 6'd0) begin errors++; $display("FAIL rst_r52: got %0d want 0", r52); end
        reset = 1'b0;
        tick();
    endtask

    // 60 long lines: count wraps at the 52nd hs_fall; monitor hsync is delayed and clipped.
    task automatic test_line_count();
        int exp_r52;
        logic exp_int;
        for (int k = 1; k <= 60; k++) begin
            run_line(LongC, LongHs, 1'b0, -1, -1);
            exp_r52 = (k < 52) ? k : k - 52;
            exp_int = (k < 52);
            checks++; if (log_r52[LongHf] !== 6'(exp_r52)) begin errors++; $display("FAIL line_r52 line %0d: got %0d want %0d", k, log_r52[LongHf], exp_r52); end
            checks++; if (log_int[LongHf] !== exp_int) begin errors++; $display("FAIL line_int_n line %0d: got %b want %b", k, log_int[LongHf], exp_int); end
            if (k == 52) begin
                checks++; if (log_int[LongHf-1] !== 1'b1) begin errors++; $display("FAIL line52_pre_int_n: got %b want 1", log_int[LongHf-1]); end
                checks++; if (log_r52[LongHf-1] !== 6'd51) begin errors++; $display("FAIL line52_pre_r52: got %0d want 51", log_r52[LongHf-1]); end
            end
            checks++; if (log_hs[7] !== 1'b0) begin errors++; $display("FAIL hs_pre_rise line %0d: got %b want 0", k, log_hs[7]); end
            checks++; if (log_hs[8] !== 1'b1) begin errors++; $display("FAIL hs_rise line %0d: got %b want 1", k, log_hs[8]); end
            checks++; if (log_hs[23] !== 1'b1) begin errors++; $display("FAIL hs_last line %0d: got %b want 1", k, log_hs[23]); end
            checks++; if (log_hs[24] !== 1'b0) begin errors++; $display("FAIL hs_width line %0d: got %b want 0", k, log_hs[24]); end
            checks++; if (log_sn[8] !== 1'b0) begin errors++; $display("FAIL sync_n_hs line %0d: got %b want 0", k, log_sn[8]); end
            checks++; if (log_sn[24] !== 1'b1) begin errors++; $display("FAIL sync_n_idle line %0d: got %b want 1", k, log_sn[24]); end
        end
    endtask

    task automatic test_hsync_clip();
        int n_high;
        run_line(LongC, 3, 1'b0, -1, -1);
        n_high = 0;
        for (int i = 0; i < LongC * 4; i++) if (log_hs[i] === 1'b1) n_high++;
        checks++; if (log_hs[8] !== 1'b1) begin errors++; $display("FAIL clip_rise: got %b want 1", log_hs[8]); end
        checks++; if (log_hs[13] !== 1'b0) begin errors++; $display("FAIL clip_fall: got %b want 0", log_hs[13]); end
        checks++; if (n_high != 5) begin errors++; $display("FAIL clip_len: got %0d cycles want 5", n_high); end
        checks++; if (log_sn[12] !== 1'b0) begin errors++; $display("FAIL clip_sync_n: got %b want 0", log_sn[12]); end
    endtask

    task automatic test_ack();
        pulse_clr();
        for (int k = 0; k < 92; k++) run_line(ShortC, ShortHs, 1'b0, -1, -1);
        checks++; if (r52 !== 6'd40) begin errors++; $display("FAIL ack_pre_r52: got %0d want 40", r52); end
        checks++; if (int_n !== 1'b0) begin errors++; $display("FAIL ack_pre_int_n: got %b want 0", int_n); end
        iorq_n = 1'b0;
        m1_n   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (int_n !== 1'b1) begin errors++; $display("FAIL ack_int_n cyc %0d: got %b want 1", c, int_n); end
            checks++; if (r52 !== 6'd8) begin errors++; $display("FAIL ack_r52 cyc %0d: got %0d want 8", c, r52); end
        end
        for (int k = 1; k <= 3; k++) begin
            run_line(ShortC, ShortHs, 1'b0, -1, -1);
            checks++; if (log_r52[ShortHf] !== 6'(8 + k)) begin errors++; $display("FAIL ack_hold_r52 line %0d: got %0d want %0d", k, log_r52[ShortHf], 8 + k); end
            checks++; if (log_int[ShortHf] !== 1'b1) begin errors++; $display("FAIL ack_hold_int_n line %0d: got %b want 1", k, log_int[ShortHf]); end
        end
        iorq_n = 1'b1;
        m1_n   = 1'b1;
        tick();
    endtask

    task automatic test_vsync_realign();
        pulse_clr();
        for (int k = 0; k < 35; k++) run_line(ShortC, ShortHs, 1'b0, -1, -1);
        run_line(ShortC, ShortHs, 1'b1, -1, -1);
        checks++; if (log_r52[ShortHf] !== 6'd36) begin errors++; $display("FAIL vs35_l1_r52: got %0d want 36", log_r52[ShortHf]); end
        checks++; if (log_int[ShortHf] !== 1'b1) begin errors++; $display("FAIL vs35_l1_int_n: got %b want 1", log_int[ShortHf]); end
        run_line(ShortC, ShortHs, 1'b1, -1, -1);
        checks++; if (log_r52[ShortHf] !== 6'd0) begin errors++; $display("FAIL vs35_l2_r52: got %0d want 0", log_r52[ShortHf]); end
        checks++; if (log_int[ShortHf] !== 1'b0) begin errors++; $display("FAIL vs35_l2_int_n: got %b want 0", log_int[ShortHf]); end
        checks++; if (log_int[ShortHf-1] !== 1'b1) begin errors++; $display("FAIL vs35_l2_pre_int_n: got %b want 1", log_int[ShortHf-1]); end
        run_line(ShortC, ShortHs, 1'b0, -1, -1);
        checks++; if (log_r52[ShortHf] !== 6'd1) begin errors++; $display("FAIL vs35_l3_r52: got %0d want 1", log_r52[ShortHf]); end

        pulse_clr();
        for (int k = 0; k < 20; k++) run_line(ShortC, ShortHs, 1'b0, -1, -1);
        run_line(ShortC, ShortHs, 1'b1, -1, -1);
        checks++; if (log_r52[ShortHf] !== 6'd21) begin errors++; $display("FAIL vs20_l1_r52: got %0d want 21", log_r52[ShortHf]); end
        run_line(ShortC, ShortHs, 1'b1, -1, -1);
        checks++; if (log_r52[ShortHf] !== 6'd0) begin errors++; $display("FAIL vs20_l2_r52: got %0d want 0", log_r52[ShortHf]); end
        checks++; if (log_int[ShortHf] !== 1'b1) begin errors++; $display("FAIL vs20_l2_int_n: got %b want 1", log_int[ShortHf]); end
        run_line(ShortC, ShortHs, 1'b0, -1, -1);
    endtask

    task automatic test_vsync_stretch();
        pulse_clr();
        for (int k = 1; k <= 30; k++) begin
            run_line(ShortC, ShortHs, 1'b1, -1, -1);
            if (k == 1) begin
                checks++; if (log_vs[0] !== 1'b0) begin errors++; $display("FAIL vs30_pre: got %b want 0", log_vs[0]); end
                checks++; if (log_vs[1] !== 1'b1) begin errors++; $display("FAIL vs30_rise: got %b want 1", log_vs[1]); end
            end
            if (k <= 25) begin
                checks++; if (log_vs[63] !== 1'b1) begin errors++; $display("FAIL vs30_hold line %0d: got %b want 1", k, log_vs[63]); end
            end
            if (k == 5) begin
                checks++; if (log_sn[63] !== 1'b0) begin errors++; $display("FAIL vs30_sync_n: got %b want 0", log_sn[63]); end
            end
            if (k == 26) begin
                checks++; if (log_vs[ShortHf-1] !== 1'b1) begin errors++; $display("FAIL vs30_l26_pre: got %b want 1", log_vs[ShortHf-1]); end
                checks++; if (log_vs[ShortHf] !== 1'b0) begin errors++; $display("FAIL vs30_l26_end: got %b want 0", log_vs[ShortHf]); end
            end
            if (k > 26) begin
                checks++; if (log_vs[63] !== 1'b0) begin errors++; $display("FAIL vs30_after line %0d: got %b want 0", k, log_vs[63]); end
            end
        end
        run_line(ShortC, ShortHs, 1'b0, -1, -1);
        for (int k = 1; k <= 8; k++) run_line(ShortC, ShortHs, 1'b1, -1, -1);
        checks++; if (log_vs[63] !== 1'b1) begin errors++; $display("FAIL vs8_hold: got %b want 1", log_vs[63]); end
        run_line(ShortC, ShortHs, 1'b0, -1, -1);
        checks++; if (log_vs[0] !== 1'b1) begin errors++; $display("FAIL vs8_pre_fall: got %b want 1", log_vs[0]); end
        checks++; if (log_vs[1] !== 1'b0) begin errors++; $display("FAIL vs8_fall: got %b want 0", log_vs[1]); end
    endtask

    task automatic test_corners();
        // irq_clr coinciding with the 52nd hs_fall wins over the new interrupt.
        pulse_clr();
        for (int k = 0; k < 51; k++) run_line(ShortC, ShortHs, 1'b0, -1, -1);
        run_line(ShortC, ShortHs, 1'b0, ShortHf, -1);
        checks++; if (log_r52[ShortHf-1] !== 6'd51) begin errors++; $display("FAIL clr52_pre_r52: got %0d want 51", log_r52[ShortHf-1]); end
        checks++; if (log_r52[ShortHf] !== 6'd0) begin errors++; $display("FAIL clr52_r52: got %0d want 0", log_r52[ShortHf]); end
        checks++; if (log_int[ShortHf] !== 1'b1) begin errors++; $display("FAIL clr52_int_n: got %b want 1", log_int[ShortHf]); end
        run_line(ShortC, ShortHs, 1'b0, -1, -1);
        checks++; if (log_r52[ShortHf] !== 6'd1) begin errors++; $display("FAIL clr52_next_r52: got %0d want 1", log_r52[ShortHf]); end

        mode_wr = 2'd2;
        tick();
        tick();
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL mode_idle: got %0d want 0", mode); end
        run_line(LongC, LongHs, 1'b0, -1, -1);
        checks++; if (log_mode[7] !== 2'd0) begin errors++; $display("FAIL mode_pre: got %0d want 0", log_mode[7]); end
        checks++; if (log_mode[8] !== 2'd2) begin errors++; $display("FAIL mode_latch: got %0d want 2", log_mode[8]); end

        run_line(LongC, LongHs, 1'b1, -1, 10);
        checks++; if (log_hs[9] !== 1'b1) begin errors++; $display("FAIL rstmid_pre_hs: got %b want 1", log_hs[9]); end
        checks++; if (log_vs[9] !== 1'b1) begin errors++; $display("FAIL rstmid_pre_vs: got %b want 1", log_vs[9]); end
        checks++; if (log_r52[9] !== 6'd2) begin errors++; $display("FAIL rstmid_pre_r52: got %0d want 2", log_r52[9]); end
        checks++; if (log_hs[10] !== 1'b0) begin errors++; $display("FAIL rstmid_hsync_o: got %b want 0", log_hs[10]); end
        checks++; if (log_vs[10] !== 1'b0) begin errors++; $display("FAIL rstmid_vsync_o: got %b want 0", log_vs[10]); end
        checks++; if (log_sn[10] !== 1'b1) begin errors++; $display("FAIL rstmid_sync_n: got %b want 1", log_sn[10]); end
        checks++; if (log_int[10] !== 1'b1) begin errors++; $display("FAIL rstmid_int_n: got %b want 1", log_int[10]); end
        checks++; if (log_mode[10] !== 2'd0) begin errors++; $display("FAIL rstmid_mode: got %0d want 0", log_mode[10]); end
        checks++; if (log_r52[10] !== 6'd0) begin errors++; $display("FAIL rstmid_r52: got %0d want 0", log_r52[10]); end
    endtask

    initial begin
        test_reset();
        test_line_count();
        test_hsync_clip();
        test_ack();
        test_vsync_realign();
        test_vsync_stretch();
        test_corners();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
